// File: rtl/pc_update_unit_pkg.sv
// pc_update_unit_pkg: shared JumpOP encoding, reset default and offset helper
// Revision: 1.0
`default_nettype none

package pc_update_unit_pkg;

    // Encoding shared with the jump controller
    localparam logic [1:0] JOP_SEQ = 2'b00;
    localparam logic [1:0] JOP_BR  = 2'b01;
    localparam logic [1:0] JOP_JR  = 2'b10;
    localparam logic [1:0] JOP_J   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HOLD = 1'b1
    } pc_mode_e;

    // Word offset to byte offset, sign-extended to 32 bits
    function automatic logic [31:0] sext_word_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_update_unit_pc_target_mux.sv
// pc_target_mux: combinational next-PC selection from the current PC and JumpOP
// Revision: 1.0
`default_nettype none

module pc_target_mux
    import pc_update_unit_pkg::*;
(
    input  logic [31:0] pc_out,
    input  logic [1:0]  JumpOP,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        is_redirect
);

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = pc_out + 32'd4;

    always_comb begin
        next_pc = w_pc_plus4;
        case (JumpOP)
            JOP_SEQ: next_pc = w_pc_plus4;
            JOP_BR:  next_pc = w_pc_plus4 + sext_word_offset(imm16);
            JOP_JR:  next_pc = rs_data;
            JOP_J:   next_pc = {w_pc_plus4[31:28], jaddr, 2'b00};
            default: next_pc = w_pc_plus4;
        endcase
    end

    assign is_redirect = (JumpOP != JOP_SEQ);

endmodule

`default_nettype wire

// File: rtl/pc_update_unit.sv
// pc_update_unit: registered PC stage with flush pulse and saturating redirect counter.
// Optional macro PC_ALIGN_CHECK_EN adds JR target alignment forcing and a sticky misalign flag.
// Revision: 1.0
`default_nettype none

module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       JumpOP,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jaddr,
    input  logic [31:0]      rs_data,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_cnt
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);

    logic [31:0]      r_pc;
    logic             r_flush;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_next_pc;
    logic [31:0]      w_load_pc;
    logic             w_is_redirect;
    pc_mode_e         w_mode;

    pc_target_mux u_target_mux (
        .pc_out      (r_pc),
        .JumpOP      (JumpOP),
        .imm16       (imm16),
        .jaddr       (jaddr),
        .rs_data     (rs_data),
        .next_pc     (w_next_pc),
        .is_redirect (w_is_redirect)
    );

    // HOLD is purely a view of the stall input; nothing about it is stored
    assign w_mode = stall ? MODE_HOLD : MODE_RUN;

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_bad_jr;

    assign w_bad_jr  = (JumpOP == JOP_JR) && (rs_data[1:0] != 2'b00);
    assign w_load_pc = (JumpOP == JOP_JR) ? {w_next_pc[31:2], 2'b00} : w_next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_mode == MODE_RUN && w_bad_jr) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign = r_misalign;
`else
    assign w_load_pc = w_next_pc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
            r_cnt   <= '0;
        end else if (w_mode == MODE_RUN) begin
            r_pc    <= w_load_pc;
            r_flush <= w_is_redirect;
            if (w_is_redirect && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_flush <= 1'b0;
        end
    end

    assign pc_out       = r_pc;
    assign pc_plus4     = r_pc + 32'd4;
    assign flush        = r_flush;
    assign redirect_cnt = r_cnt;

endmodule

`default_nettype wire
